// File: rtl/ioctl_loader_pkg.sv
// Shared types and helpers for the ioctl ROM region loader.
package ioctl_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } load_state_t;

    localparam logic [7:0] ROM_INDEX = 8'd0;
    localparam logic [7:0] DIP_INDEX = 8'd254;

    // Region-relative word address of a byte address; word_bytes is 1, 2 or 4.
    function automatic logic [31:0] rel_word_addr(input logic [31:0] addr,
                                                  input logic [31:0] base,
                                                  input int unsigned word_bytes);
        logic [31:0] diff;
        diff = addr - base;
        if (word_bytes == 4) begin
            return diff >> 2;
        end else if (word_bytes == 2) begin
            return diff >> 1;
        end
        return diff;
    endfunction

endpackage

// File: rtl/ioctl_region_decode.sv
// Priority decode of a byte address against ascending region bases.
// Base i sits at the i-th slice counted from the MSB end of REGION_BASE.
module ioctl_region_decode #(
    parameter int unsigned                REGIONS     = 4,
    parameter int unsigned                ADDR_W      = 25,
    parameter logic [REGIONS*ADDR_W-1:0]  REGION_BASE = {25'h0, 25'h8000, 25'h10000, 25'h18000},
    localparam int unsigned               RW          = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [RW-1:0]     o_region,
    output logic              o_oor
);

    // Highest base not above the address wins; below base 0 is out of range.
    always_comb begin
        o_region = '0;
        o_oor    = (i_addr < REGION_BASE[(REGIONS-1)*ADDR_W +: ADDR_W]);
        for (int unsigned i = 0; i < REGIONS; i++) begin
            if (i_addr >= REGION_BASE[(REGIONS-1-i)*ADDR_W +: ADDR_W]) begin
                o_region = RW'(i);
            end
        end
    end

endmodule

// File: rtl/ioctl_region_loader.sv
// Demultiplexes the hps_io ROM download stream into region write ports,
// packing bytes into words and stalling hps_io while a word is pending.
// Optional DIP capture of index 254 is built when IOCTL_DIP_CAPTURE_EN is defined.
module ioctl_region_loader
    import ioctl_loader_pkg::*;
#(
    parameter int unsigned               REGIONS     = 4,
    parameter int unsigned               WORD_BYTES  = 1,
    parameter int unsigned               ADDR_W      = 25,
    parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = {25'h0, 25'h8000, 25'h10000, 25'h18000},
    parameter int unsigned               DIP_BYTES   = 8
) (
    input  logic                    i_clk_sys,
    input  logic                    i_reset,
    input  logic                    i_ioctl_download,
    input  logic [7:0]              i_ioctl_index,
    input  logic                    i_ioctl_wr,
    input  logic [ADDR_W-1:0]       i_ioctl_addr,
    input  logic [7:0]              i_ioctl_dout,
    output logic                    o_ioctl_wait,
    output logic [ADDR_W-1:0]       o_rom_addr,
    output logic [8*WORD_BYTES-1:0] o_rom_data,
    output logic [REGIONS-1:0]      o_rom_we,
    input  logic                    i_rom_ready,
    output logic [8*DIP_BYTES-1:0]  o_dip_sw,
    output logic                    o_load_busy,
    output logic                    o_load_done,
    output logic                    o_overrun
);

    localparam int unsigned RW     = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int unsigned LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned DW     = 8 * WORD_BYTES;

    load_state_t           r_state,   w_state_d;
    logic [DW-1:0]         r_buf,     w_buf_d;
    logic [WORD_BYTES-1:0] r_mask,    w_mask_d;
    logic                  r_pending, w_pending_d;
    logic [RW-1:0]         r_region,  w_region_d;
    logic [ADDR_W-1:0]     r_addr,    w_addr_d;
    logic                  r_overrun, w_overrun_d;

    logic [ADDR_W-1:0]     w_aligned;
    logic [RW-1:0]         w_dec_region;
    logic                  w_dec_oor;
    logic [ADDR_W-1:0]     w_base;
    logic [ADDR_W-1:0]     w_rel_addr;
    logic [LANE_W-1:0]     w_lane;
    logic                  w_last_lane;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_rom_wr;

    assign w_aligned = i_ioctl_addr & ~ADDR_W'(WORD_BYTES - 1);

    ioctl_region_decode #(
        .REGIONS     (REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE)
    ) u_decode (
        .i_addr   (w_aligned),
        .o_region (w_dec_region),
        .o_oor    (w_dec_oor)
    );

    // Base address of the decoded region.
    always_comb begin
        w_base = '0;
        for (int unsigned i = 0; i < REGIONS; i++) begin
            if (w_dec_region == RW'(i)) begin
                w_base = REGION_BASE[(REGIONS-1-i)*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_rel_addr  = ADDR_W'(rel_word_addr(32'(w_aligned), 32'(w_base), WORD_BYTES));
    assign w_lane      = LANE_W'(i_ioctl_addr % ADDR_W'(WORD_BYTES));
    assign w_last_lane = (32'(w_lane) == WORD_BYTES - 1);
    assign w_accept    = r_pending & i_rom_ready;
    assign w_stall     = r_pending & ~i_rom_ready;
    assign w_rom_wr    = i_ioctl_wr && (i_ioctl_index == ROM_INDEX);

    // Next-state: byte assembly, pending word handshake and load sequencing.
    always_comb begin
        w_state_d   = r_state;
        w_buf_d     = r_buf;
        w_mask_d    = r_mask;
        w_pending_d = r_pending;
        w_region_d  = r_region;
        w_addr_d    = r_addr;
        w_overrun_d = r_overrun;

        // Acceptance frees the buffer first so a byte in the same cycle is kept.
        if (w_accept) begin
            w_pending_d = 1'b0;
            w_buf_d     = '0;
            w_mask_d    = '0;
        end

        case (r_state)
            StIdle: begin
                if (i_ioctl_download && i_ioctl_index == ROM_INDEX) begin
                    w_state_d   = StLoad;
                    w_buf_d     = '0;
                    w_mask_d    = '0;
                    w_pending_d = 1'b0;
                    w_overrun_d = 1'b0;
                end
            end
            StLoad: begin
                if (w_rom_wr) begin
                    if (w_stall || w_dec_oor) begin
                        w_overrun_d = 1'b1;
                    end else begin
                        w_buf_d[8*w_lane +: 8] = i_ioctl_dout;
                        w_mask_d[w_lane]       = 1'b1;
                        w_region_d             = w_dec_region;
                        w_addr_d               = w_rel_addr;
                        if (w_last_lane) begin
                            w_pending_d = 1'b1;
                        end
                    end
                end
                if (!i_ioctl_download) begin
                    w_state_d = StFlush;
                end
            end
            StFlush: begin
                if (!r_pending) begin
                    if (r_mask != '0) begin
                        w_pending_d = 1'b1;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any pending word without a done pulse.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_buf     <= '0;
            r_mask    <= '0;
            r_pending <= 1'b0;
            r_region  <= '0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_buf     <= w_buf_d;
            r_mask    <= w_mask_d;
            r_pending <= w_pending_d;
            r_region  <= w_region_d;
            r_addr    <= w_addr_d;
            r_overrun <= w_overrun_d;
        end
    end

    assign o_rom_we     = r_pending ? (REGIONS'(1) << r_region) : '0;
    assign o_rom_data   = r_pending ? r_buf : '0;
    assign o_rom_addr   = r_addr;
    assign o_ioctl_wait = w_stall;
    assign o_load_busy  = (r_state != StIdle);
    assign o_load_done  = (r_state == StDone);
    assign o_overrun    = r_overrun;

`ifdef IOCTL_DIP_CAPTURE_EN
    logic [8*DIP_BYTES-1:0] r_dip;

    // Capture DIP bytes from the index-254 stream in any load state.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_dip <= '0;
        end else if (i_ioctl_wr && i_ioctl_index == DIP_INDEX &&
                     i_ioctl_addr < ADDR_W'(DIP_BYTES)) begin
            r_dip[{i_ioctl_addr[2:0], 3'b000} +: 8] <= i_ioctl_dout;
        end
    end

    assign o_dip_sw = r_dip;
`else
    assign o_dip_sw = '0;
`endif

endmodule

// File: doc/ioctl_region_loader.md
# ioctl_region_loader

Parametrised successor to the core's ad hoc download plumbing. It demultiplexes the hps_io ioctl byte stream for index 0 (ROM) into REGIONS ROM regions, packs bytes into WORD_BYTES-wide words, and exerts backpressure via ioctl_wait when a target is not ready. It captures index-254 DIP bytes and signals load completion. It sits between hps_io and the game core inside emu.

## Interface
- REGIONS, 4: number of ROM regions (1..8).
- WORD_BYTES, 1: bytes per output word (1, 2 or 4).
- ADDR_W, 25: ioctl address width.
- REGION_BASE, {25'h0, 25'h8000, 25'h10000, 25'h18000}: packed ascending byte base per region; region i spans [BASE[i], BASE[i+1]); the last region ends at 2^ADDR_W.
- DIP_BYTES, 8: DIP bytes captured.
- clk_sys  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  stream index.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- rom_addr  out  ADDR_W  region-relative word address.
- rom_data  out  8*WORD_BYTES  little-endian packed word.
- rom_we  out  REGIONS  one-hot write request.
- rom_ready  in  1  target accepts when rom_we!=0 && rom_ready.
- dip_sw  out  8*DIP_BYTES  captured DIP bytes, byte k at [8k+7:8k].
- load_busy  out  1  high from ROM download start until done.
- load_done  out  1  one-cycle pulse at end of ROM load.
- overrun  out  1  sticky: a byte arrived while a word was pending.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE -> LOAD when ioctl_download=1 and ioctl_index=0. The assembly buffer, byte-valid mask and overrun are cleared.
- In LOAD, each ioctl_wr writes byte lane ioctl_addr mod WORD_BYTES of the buffer and sets its valid bit.
- The word completes when lane WORD_BYTES-1 is written. On completion it is registered as pending with region = decode(word-aligned ioctl_addr) and rom_addr = (ioctl_addr - BASE[region]) / WORD_BYTES.
- Unwritten lanes of a pending word are 0.
- A pending word holds rom_we[region]=1 until accepted. On acceptance, rom_we, the buffer and the mask are cleared.
- ioctl_wait = pending && !accepted-this-cycle.
- An ioctl_wr while pending sets overrun and drops the byte.
- LOAD -> FLUSH on ioctl_download falling. In FLUSH, a nonzero mask emits the partial word as pending.
- FLUSH -> DONE once nothing is pending. DONE pulses load_done and returns to IDLE.
- load_busy = state != IDLE.
- Addresses beyond the last base map to region REGIONS-1.
- Addresses below BASE[0] are dropped and set overrun.
- A download with index != 0 or 254 is ignored entirely.

## Timing
- rom_we and rom_data are valid on the cycle after the completing ioctl_wr; registered, 1-cycle latency.
- Acceptance clears rom_we on the next edge. Back-to-back words with rom_ready=1 sustain one word per WORD_BYTES writes.
- ioctl_wait rises on the same edge that rom_we rises.
- Reset values: all outputs 0, dip_sw 0, state IDLE.
- Reset mid-load aborts without a load_done pulse, and the pending word is discarded.
- If download restarts while in DONE, the restart is taken from IDLE on the following cycle.

## Configuration
- IOCTL_DIP_CAPTURE_EN defined:
  - ioctl_wr with ioctl_index=254 and ioctl_addr < DIP_BYTES writes dip_sw byte ioctl_addr[2:0] on the next edge, in any FSM state.
  - dip_sw persists across ROM loads and is cleared only by reset.
- IOCTL_DIP_CAPTURE_EN undefined: dip_sw is constant 0 and no capture logic is built.

## Structure
- Package ioctl_loader_pkg holds:
  - the state enum;
  - localparams ROM_INDEX=0 and DIP_INDEX=254;
  - a function computing the region-relative word address.
- Sub-module ioctl_region_decode is a combinational priority compare of an address against REGION_BASE, returning the region index and an out-of-range flag.

## Test plan
- Region routing: WORD_BYTES=1, bytes 0xA5 at 0x0000 and 0x5A at 0x8001, rom_ready=1 -> rom_we=4'b0001 with addr 0/data A5, then 4'b0010 with addr 1/data 5A; load_done pulses once after download falls.
- Packing: WORD_BYTES=2, bytes 0x34@0x10, 0x12@0x11 -> a single rom_we[0] with rom_data=16'h1234 and rom_addr=8.
- Backpressure: rom_ready=0 for 5 cycles after a word completes -> ioctl_wait high for exactly those cycles; a byte injected during the stall sets overrun and is not written.
- Partial flush: WORD_BYTES=4, download ends after 3 bytes 11,22,33 at 0x0 -> FLUSH emits rom_data=32'h00332211, then load_done.
- DIP capture (macro defined): index 254, bytes 0x7F@0 and 0x0C@2 -> dip_sw[7:0]=7F, dip_sw[23:16]=0C; no rom_we and no load_done. With the macro undefined, dip_sw stays 0.
- Reset mid-load: assert reset while rom_we is pending -> all outputs 0 asynchronously and no load_done pulse.
